// File: rtl/frv_asi_seq.sv
// frv_asi_seq: crypto ISE sequencer for AES SubBytes and SHA256 sigma instructions.
//
// Ports
//   g_clk       global clock, rising edge
//   g_resetn    asynchronous active-low reset
//   asi_valid   instruction present; operands held stable until asi_ready
//   asi_ready   one-cycle completion pulse, asi_result valid in that cycle
//   asi_flush   synchronous abort of any in-flight operation
//   asi_uop     0xx: aessub.{enc,dec,encrot,decrot}, 1xx: sha256.s0..s3
//   asi_rs1/2   source operands
//   asi_result  result, zero whenever asi_ready is low
//   asi_busy    AES sequence in progress (BUSY or DONE)
//
// SHA2 ops complete combinationally. AES ops go IDLE -> BUSY x (4/AES_LANES) -> DONE,
// substituting AES_LANES bytes of the latched word per BUSY cycle.
module frv_asi_seq #(
  parameter int unsigned AES_LANES     = 1,
  parameter bit          XC_CLASS_AES  = 1'b1,
  parameter bit          XC_CLASS_SHA2 = 1'b1
) (
  input  logic        g_clk,
  input  logic        g_resetn,
  input  logic        asi_valid,
  output logic        asi_ready,
  input  logic        asi_flush,
  input  logic [2:0]  asi_uop,
  input  logic [31:0] asi_rs1,
  input  logic [31:0] asi_rs2,
  output logic [31:0] asi_result,
  output logic        asi_busy
);

  if (!(AES_LANES == 1 || AES_LANES == 2 || AES_LANES == 4)) begin : g_bad_lanes
    $error("frv_asi_seq: AES_LANES must be 1, 2 or 4");
  end

  // Counter step; 4 lanes wraps to 0 so a single BUSY cycle reaches DONE.
  localparam logic [1:0] LaneStep = AES_LANES[1:0];

  typedef enum logic [1:0] {StIdle, StBusy, StDone} state_e;

  state_e      state_q, state_d;
  logic [1:0]  cnt_q, cnt_d;
  logic [31:0] w_q, w_d;
  logic [1:0]  uop_q, uop_d;
  logic [31:0] res_q, res_d;

  logic        ready_c;
  logic [31:0] result_c;
  logic [31:0] sha_res;
  logic [1:0]  idx;

  // Low half of rs2 never feeds any result.
  logic unused_rs2;
  assign unused_rs2 = ^asi_rs2[15:0];

  function automatic logic [31:0] ror32(input logic [31:0] x, input int unsigned n);
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] x, input int unsigned n);
    return (x << n) | (x >> (8 - n));
  endfunction

  // GF(2^8) multiply modulo x^8 + x^4 + x^3 + x + 1.
  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] aa;
    p  = 8'h00;
    aa = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ aa;
      aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  // Multiplicative inverse as x^254 = prod x^(2^k), k = 1..7; maps 0 to 0.
  function automatic logic [7:0] gf_inv(input logic [7:0] x);
    logic [7:0] sq;
    logic [7:0] r;
    sq = x;
    r  = 8'h01;
    for (int k = 1; k < 8; k++) begin
      sq = gf_mul(sq, sq);
      r  = gf_mul(r, sq);
    end
    return r;
  endfunction

  // Forward S-box: inverse then affine. Inverse S-box: inverse affine then inverse.
  function automatic logic [7:0] aes_sbox(input logic [7:0] x, input logic inv);
    logic [7:0] a;
    logic [7:0] r;
    a = inv ? (rotl8(x, 1) ^ rotl8(x, 3) ^ rotl8(x, 6) ^ 8'h05) : x;
    r = gf_inv(a);
    if (!inv) r = r ^ rotl8(r, 1) ^ rotl8(r, 2) ^ rotl8(r, 3) ^ rotl8(r, 4) ^ 8'h63;
    return r;
  endfunction

  always_comb begin
    sha_res = 32'h0;
    unique case (asi_uop[1:0])
      2'b00: sha_res = ror32(asi_rs1, 7)  ^ ror32(asi_rs1, 18) ^ (asi_rs1 >> 3);
      2'b01: sha_res = ror32(asi_rs1, 17) ^ ror32(asi_rs1, 19) ^ (asi_rs1 >> 10);
      2'b10: sha_res = ror32(asi_rs1, 2)  ^ ror32(asi_rs1, 13) ^ ror32(asi_rs1, 22);
      2'b11: sha_res = ror32(asi_rs1, 6)  ^ ror32(asi_rs1, 11) ^ ror32(asi_rs1, 25);
      default: sha_res = 32'h0;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    w_d      = w_q;
    uop_d    = uop_q;
    res_d    = res_q;
    ready_c  = 1'b0;
    result_c = 32'h0;
    idx      = 2'b00;

    if (asi_flush) begin
      state_d = StIdle;
      cnt_d   = 2'b00;
      w_d     = 32'h0;
      uop_d   = 2'b00;
      res_d   = 32'h0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (asi_valid) begin
            if (asi_uop[2]) begin
              ready_c  = 1'b1;
              result_c = XC_CLASS_SHA2 ? sha_res : 32'h0;
            end else if (!XC_CLASS_AES) begin
              ready_c = 1'b1;
            end else begin
              state_d = StBusy;
              w_d     = {asi_rs2[31:16], asi_rs1[15:0]};
              uop_d   = asi_uop[1:0];
              cnt_d   = 2'b00;
              res_d   = 32'h0;
            end
          end
        end
        StBusy: begin
          if (!asi_valid) begin
            state_d = StIdle;
            cnt_d   = 2'b00;
            res_d   = 32'h0;
          end else begin
            for (int unsigned j = 0; j < AES_LANES; j++) begin
              idx = cnt_q + 2'(j);
              res_d[{idx, 3'b000} +: 8] = aes_sbox(w_q[{idx, 3'b000} +: 8], uop_q[0]);
            end
            cnt_d = cnt_q + LaneStep;
            if (cnt_d == 2'b00) state_d = StDone;
          end
        end
        StDone: begin
          state_d = StIdle;
          cnt_d   = 2'b00;
          if (!asi_valid) begin
            res_d = 32'h0;
          end else begin
            ready_c  = 1'b1;
            result_c = uop_q[1] ? {res_q[23:0], res_q[31:24]} : res_q;
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge g_clk or negedge g_resetn) begin
    if (!g_resetn) begin
      state_q <= StIdle;
      cnt_q   <= 2'b00;
      w_q     <= 32'h0;
      uop_q   <= 2'b00;
      res_q   <= 32'h0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      w_q     <= w_d;
      uop_q   <= uop_d;
      res_q   <= res_d;
    end
  end

  // SHA2 completion is combinational on asi_valid, so gate with reset to keep
  // all outputs quiet while reset is held.
  assign asi_ready  = ready_c & g_resetn;
  assign asi_result = asi_ready ? result_c : 32'h0;
  assign asi_busy   = (state_q != StIdle);

endmodule

// File: tb/tb_frv_asi_seq.sv
// Bench for frv_asi_seq: four instances (1, 2, 4 lanes, and both classes disabled)
// share stimulus; only the selected instance sees asi_valid.
module tb_frv_asi_seq;

  logic        clk;
  logic        rst_n;
  logic        valid;
  logic        flush;
  logic [2:0]  uop;
  logic [31:0] rs1;
  logic [31:0] rs2;
  logic [1:0]  sel;

  logic [3:0]  valid_v;
  logic [3:0]  ready_w;
  logic [3:0]  busy_w;
  logic [31:0] result_w [4];

  logic        ready_s;
  logic        busy_s;
  logic [31:0] result_s;

  int          n_chk;
  int          n_err;
  logic [31:0] sb [$];

  logic [7:0]  sbox_t [256];
  logic [7:0]  isbox_t [256];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign valid_v  = valid ? (4'b0001 << sel) : 4'b0000;
  assign ready_s  = ready_w[sel];
  assign busy_s   = busy_w[sel];
  assign result_s = result_w[sel];

  frv_asi_seq #(.AES_LANES(1)) u_dut_l1 (
    .g_clk(clk), .g_resetn(rst_n), .asi_valid(valid_v[0]), .asi_ready(ready_w[0]),
    .asi_flush(flush), .asi_uop(uop), .asi_rs1(rs1), .asi_rs2(rs2),
    .asi_result(result_w[0]), .asi_busy(busy_w[0])
  );
  frv_asi_seq #(.AES_LANES(2)) u_dut_l2 (
    .g_clk(clk), .g_resetn(rst_n), .asi_valid(valid_v[1]), .asi_ready(ready_w[1]),
    .asi_flush(flush), .asi_uop(uop), .asi_rs1(rs1), .asi_rs2(rs2),
    .asi_result(result_w[1]), .asi_busy(busy_w[1])
  );
  frv_asi_seq #(.AES_LANES(4)) u_dut_l4 (
    .g_clk(clk), .g_resetn(rst_n), .asi_valid(valid_v[2]), .asi_ready(ready_w[2]),
    .asi_flush(flush), .asi_uop(uop), .asi_rs1(rs1), .asi_rs2(rs2),
    .asi_result(result_w[2]), .asi_busy(busy_w[2])
  );
  frv_asi_seq #(.AES_LANES(1), .XC_CLASS_AES(1'b0), .XC_CLASS_SHA2(1'b0)) u_dut_off (
    .g_clk(clk), .g_resetn(rst_n), .asi_valid(valid_v[3]), .asi_ready(ready_w[3]),
    .asi_flush(flush), .asi_uop(uop), .asi_rs1(rs1), .asi_rs2(rs2),
    .asi_result(result_w[3]), .asi_busy(busy_w[3])
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [3:0] hex_nib(input byte c);
    if (c >= 8'h30 && c <= 8'h39) return 4'(c - 8'h30);
    return 4'(c - 8'h61 + 8'd10);
  endfunction

  task automatic load_sbox();
    string rows [16];
    byte   hi;
    byte   lo;
    rows = '{"637c777bf26b6fc53001672bfed7ab76", "ca82c97dfa5947f0add4a2af9ca472c0",
             "b7fd9326363ff7cc34a5e5f171d83115", "04c723c31896059a071280e2eb27b275",
             "09832c1a1b6e5aa0523bd6b329e32f84", "53d100ed20fcb15b6acbbe394a4c58cf",
             "d0efaafb434d338545f9027f503c9fa8", "51a3408f929d38f5bcb6da2110fff3d2",
             "cd0c13ec5f974417c4a77e3d645d1973", "60814fdc222a908846eeb814de5e0bdb",
             "e0323a0a4906245cc2d3ac629195e479", "e7c8376d8dd54ea96c56f4ea657aae08",
             "ba78252e1ca6b4c6e8dd741f4bbd8b8a", "703eb5664803f60e613557b986c11d9e",
             "e1f8981169d98e949b1e87e9ce5528df", "8ca1890dbfe6426841992d0fb054bb16"};
    for (int r = 0; r < 16; r++) begin
      for (int c = 0; c < 16; c++) begin
        hi = rows[r][2*c];
        lo = rows[r][2*c+1];
        sbox_t[r*16+c] = {hex_nib(hi), hex_nib(lo)};
      end
    end
    for (int i = 0; i < 256; i++) isbox_t[sbox_t[i]] = 8'(i);
  endtask

  function automatic logic [31:0] rr(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic logic [31:0] model(input logic [2:0] u, input logic [31:0] a,
                                        input logic [31:0] b, input bit en);
    logic [31:0] w;
    logic [31:0] r;
    if (!en) return 32'h0;
    if (u[2]) begin
      case (u[1:0])
        2'b00:   return rr(a, 7) ^ rr(a, 18) ^ (a >> 3);
        2'b01:   return rr(a, 17) ^ rr(a, 19) ^ (a >> 10);
        2'b10:   return rr(a, 2) ^ rr(a, 13) ^ rr(a, 22);
        default: return rr(a, 6) ^ rr(a, 11) ^ rr(a, 25);
      endcase
    end
    w = {b[31:16], a[15:0]};
    for (int i = 0; i < 4; i++)
      r[8*i +: 8] = u[0] ? isbox_t[w[8*i +: 8]] : sbox_t[w[8*i +: 8]];
    if (u[1]) r = {r[23:0], r[31:24]};
    return r;
  endfunction

  // Drive one instruction, push its expected result, wait (bounded) for asi_ready.
  task automatic run_op(input int inst, input logic [2:0] u, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp,
                        input bit hold, input bit scramble);
    int lat;
    int exp_lat;
    bit seen;
    int lanes;
    lanes   = (inst == 0) ? 1 : (inst == 1) ? 2 : 4;
    exp_lat = (u[2] || inst == 3) ? 0 : 4 / lanes + 1;
    sel   = 2'(inst);
    uop   = u;
    rs1   = a;
    rs2   = b;
    valid = 1'b1;
    sb.push_back(exp);
    lat  = 0;
    seen = 1'b0;
    while (!seen && lat <= 20) begin
      @(negedge clk);
      if (ready_s) begin
        seen = 1'b1;
      end else begin
        if (lat == 1) check("busy_during_aes", 32'(busy_s), 32'd1);
        @(posedge clk);
        #1;
        lat++;
        if (scramble) begin
          rs1 = $urandom;
          rs2 = $urandom;
          uop = 3'($urandom);
        end
      end
    end
    if (!seen) begin
      check("ready_timeout", 32'd0, 32'd1);
      sb.delete();
    end else begin
      check("latency", 32'(lat), 32'(exp_lat));
    end
    @(posedge clk);
    #1;
    if (!hold) valid = 1'b0;
  endtask

  initial begin
    n_chk = 0;
    n_err = 0;
    load_sbox();
    rst_n = 1'b0;
    valid = 1'b0;
    flush = 1'b0;
    sel   = 2'd0;
    uop   = 3'b000;
    rs1   = 32'h0;
    rs2   = 32'h0;

    fork
      forever begin
        @(negedge clk);
        if (ready_s) begin
          if (sb.size() == 0) check("spurious_ready", 32'(ready_s), 32'd0);
          else check("result", result_s, sb.pop_front());
        end else begin
          check("result_when_not_ready", result_s, 32'h0);
        end
      end
      begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
      end
    join_none

    // Reset holds every output low, even with a SHA2 op presented.
    #2;
    valid = 1'b1;
    uop   = 3'b100;
    rs1   = 32'h1;
    #1;
    check("rst_ready", 32'(ready_s), 32'd0);
    check("rst_result", result_s, 32'h0);
    check("rst_busy", 32'(busy_s), 32'd0);
    valid = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    run_op(0, 3'b100, 32'h1, 32'h0, 32'h02004000, 1'b0, 1'b0);
    run_op(0, 3'b110, 32'h1, 32'h0, 32'h40080400, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      rs1 = $urandom;
      run_op(0, {1'b1, 2'(i)}, rs1, 32'h0, model({1'b1, 2'(i)}, rs1, 32'h0, 1'b1),
             1'b0, 1'b0);
    end

    for (int k = 0; k < 3; k++) begin
      run_op(k, 3'b000, 32'h00005300, 32'h0, 32'h6363ED63, 1'b0, 1'b0);
      run_op(k, 3'b010, 32'h00005300, 32'h0, 32'h63ED6363, 1'b0, 1'b0);
    end

    // Operands and uop scrambled during BUSY/DONE must not matter.
    run_op(0, 3'b001, 32'h00006363, 32'h63630000, 32'h0, 1'b0, 1'b1);

    for (int k = 0; k < 3; k++) begin
      for (int i = 0; i < 4; i++) begin
        logic [31:0] a;
        logic [31:0] b;
        a = $urandom;
        b = $urandom;
        run_op(k, 3'(i), a, b, model(3'(i), a, b, 1'b1), i[0], 1'b0);
      end
    end
    valid = 1'b0;
    @(posedge clk);
    #1;

    // Flush in the second BUSY cycle.
    sel = 2'd0; uop = 3'b000; rs1 = 32'h00005300; rs2 = 32'h0; valid = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    flush = 1'b1;
    @(negedge clk);
    check("flush_busy_ready", 32'(ready_s), 32'd0);
    @(posedge clk); #1;
    flush = 1'b0;
    valid = 1'b0;
    @(negedge clk);
    check("flush_busy_idle", 32'(busy_s), 32'd0);
    @(posedge clk); #1;
    run_op(0, 3'b101, 32'h1, 32'h0, 32'h0000A000, 1'b0, 1'b0);

    // Flush suppresses a SHA2 completion.
    sel = 2'd0; uop = 3'b100; rs1 = 32'h1; valid = 1'b1; flush = 1'b1;
    #1;
    check("flush_sha_ready", 32'(ready_s), 32'd0);
    check("flush_sha_result", result_s, 32'h0);
    @(posedge clk); #1;
    flush = 1'b0;
    valid = 1'b0;

    // Flush in DONE on the 4-lane instance.
    sel = 2'd2; uop = 3'b000; rs1 = 32'h00005300; rs2 = 32'h0; valid = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    flush = 1'b1;
    #1;
    check("flush_done_ready", 32'(ready_s), 32'd0);
    @(posedge clk); #1;
    flush = 1'b0;
    valid = 1'b0;
    @(negedge clk);
    check("flush_done_idle", 32'(busy_s), 32'd0);
    @(posedge clk); #1;

    // asi_valid dropped mid-BUSY aborts without a pulse.
    sel = 2'd1; uop = 3'b000; rs1 = 32'h00005300; rs2 = 32'h0; valid = 1'b1;
    @(posedge clk); #1;
    valid = 1'b0;
    @(negedge clk);
    check("drop_ready", 32'(ready_s), 32'd0);
    @(posedge clk); #1;
    @(negedge clk);
    check("drop_idle", 32'(busy_s), 32'd0);
    @(posedge clk); #1;
    run_op(1, 3'b011, 32'h00005300, 32'h0, model(3'b011, 32'h00005300, 32'h0, 1'b1),
           1'b0, 1'b0);

    // Disabled classes complete at once with a zero result.
    run_op(3, 3'b000, 32'h00005300, 32'h0, 32'h0, 1'b0, 1'b0);
    run_op(3, 3'b110, 32'h1, 32'h0, 32'h0, 1'b0, 1'b0);
    check("off_busy", 32'(busy_w[3]), 32'd0);

    // Asynchronous reset mid-BUSY, then back-to-back AES ops.
    sel = 2'd0; uop = 3'b000; rs1 = 32'h00005300; rs2 = 32'h0; valid = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    check("rst_mid_busy", 32'(busy_s), 32'd0);
    check("rst_mid_ready", 32'(ready_s), 32'd0);
    check("rst_mid_result", result_s, 32'h0);
    valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    run_op(0, 3'b000, 32'h00005300, 32'h0, 32'h6363ED63, 1'b1, 1'b0);
    run_op(0, 3'b010, 32'h00005300, 32'h0, 32'h63ED6363, 1'b1, 1'b0);
    run_op(0, 3'b001, 32'h00006363, 32'h63630000, 32'h0, 1'b0, 1'b0);

    @(posedge clk); #1;
    check("scoreboard_drained", 32'(sb.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/frv_asi_seq.md
FRV_ASI_SEQ -- requirements
Module: frv_asi_seq

Interface
REQ-001 The block SHALL have parameter AES_LANES, default 1, giving S-box lanes per cycle; legal values are 1, 2 and 4, and any other value SHALL be an elaboration error.
REQ-002 The block SHALL have parameter XC_CLASS_AES, default 1'b1, which enables the AES SubBytes instructions.
REQ-003 The block SHALL have parameter XC_CLASS_SHA2, default 1'b1, which enables the SHA256 sigma instructions.
REQ-004 Port g_clk: input, 1 bit, global clock; all state updates on its rising edge.
REQ-005 Port g_resetn: input, 1 bit, reset; asynchronous, active-low.
REQ-006 Port asi_valid: input, 1 bit, instruction present; held high with stable operands until asi_ready.
REQ-007 Port asi_ready: output, 1 bit, one-cycle completion pulse; asi_result is valid in that cycle.
REQ-008 Port asi_flush: input, 1 bit, synchronous abort of any in-flight operation.
REQ-009 Port asi_uop: input, 3 bits, operation select:
- 000 aessub.enc, 001 aessub.dec, 010 aessub.encrot, 011 aessub.decrot
- 100 sha256.s0, 101 s1, 110 s2, 111 s3
REQ-010 Port asi_rs1: input, 32 bits, source register 1.
REQ-011 Port asi_rs2: input, 32 bits, source register 2.
REQ-012 Port asi_result: output, 32 bits, instruction result.
REQ-013 Port asi_busy: output, 1 bit, high while the AES FSM is in BUSY or DONE.

Function
REQ-014 asi_result SHALL be 32'h0 in every cycle where asi_ready is 0.
REQ-015 SHA2 ops (uop[2]=1) SHALL be combinational: asi_ready=1 in the same cycle as asi_valid, with no state change.
REQ-016 SHA2 results, rotates on rs1 (ror=rotate right, shr=logical right):
- s0 = ror7^ror18^shr3
- s1 = ror17^ror19^shr10
- s2 = ror2^ror13^ror22
- s3 = ror6^ror11^ror25
REQ-017 The AES input word SHALL be w = {rs2[31:16], rs1[15:0]}, and each result byte SHALL be r[i] = S(w[i]), using the FIPS-197 forward S-box for enc/encrot and the inverse S-box for dec/decrot.
REQ-018 For rot variants (uop[1]=1) the final word SHALL be rotated left by 8 bits before output.
REQ-019 The AES FSM SHALL have states IDLE, BUSY and DONE, with a 2-bit byte counter cnt and latched operand, uop and result registers.
REQ-020 In IDLE, asi_valid with an AES uop SHALL latch w and uop, clear cnt and the result register, and go to BUSY; asi_ready SHALL stay 0 that cycle.
REQ-021 Each BUSY cycle SHALL substitute AES_LANES bytes into the result register, starting at byte cnt with byte 0 first, and then set cnt += AES_LANES (mod 4).
REQ-022 BUSY SHALL go to DONE after exactly 4/AES_LANES cycles.
REQ-023 In DONE, asi_ready SHALL be 1 for exactly one cycle, with the (rotated) result on asi_result, and the FSM SHALL return to IDLE.
REQ-024 AES latency, from the first asi_valid cycle to the asi_ready cycle, SHALL be 4/AES_LANES+1 cycles: 5, 3 or 2.
REQ-025 After asi_ready, an asi_valid that is still high in the next cycle SHALL be treated as a new instruction.
REQ-026 Operand or uop changes while in BUSY or DONE SHALL be ignored, since the latched values are used.
REQ-027 If asi_valid falls while in BUSY or DONE, the FSM SHALL return to IDLE next cycle with no asi_ready and the result register cleared.
REQ-028 asi_flush SHALL take priority over all other inputs:
- the next state SHALL be IDLE, with cnt, the latched operands and the result register set to 0
- asi_ready SHALL be 0 in any cycle where asi_flush is 1, including a SHA2 op and the DONE state.
REQ-029 A disabled class (XC_CLASS_*=0) SHALL complete immediately: asi_ready=1 in the same cycle, asi_result=0, and the FSM is not entered.
REQ-030 asi_valid=0 in IDLE SHALL hold all state.

Reset
REQ-031 g_resetn=0 SHALL asynchronously force the FSM to IDLE and set cnt, the latched w/uop and the result register to 0.
REQ-032 During reset asi_ready, asi_result and asi_busy SHALL all be 0.
REQ-033 Reset deassertion SHALL be synchronised externally, and the first rising edge after release SHALL act on asi_valid normally.
REQ-034 An assertion of reset in BUSY or DONE SHALL abort the operation with no asi_ready pulse.

Verification
REQ-035 sha256.s0, rs1=32'h00000001 -> asi_ready=1 same cycle, asi_result=32'h02004000; sha256.s2 with the same rs1 -> 32'h40080400.
REQ-036 aessub.enc, rs1=32'h00005300, rs2=0, AES_LANES=1 -> asi_busy high, asi_ready pulses on the 5th cycle with 32'h6363ED63; encrot gives 32'h63ED6363; repeat with AES_LANES=2 (3rd cycle) and 4 (2nd cycle).
REQ-037 aessub.dec, rs1=32'h00006363, rs2=32'h63630000 -> asi_result=32'h00000000; the asi_rs1 value changed mid-BUSY must not alter the result.
REQ-038 Assert asi_flush in the second BUSY cycle -> no asi_ready, asi_busy=0 next cycle; a following sha256.s1 completes correctly.
REQ-039 Assert g_resetn=0 between clock edges mid-BUSY -> asi_busy, asi_ready and asi_result are 0 immediately; after release, back-to-back AES ops complete with a one-cycle asi_ready each.
